mult_arbiter: RTL
=================

Name: mult_arbiter

Overview:
- Shares one shift-add multiplier (sequencer plus add/shift datapath) between NREQ requesters.
- Picks requesters round-robin, loads the winner's operands and launches the multiplier with a start pulse.
- Waits for the multiplier's ready, captures the 2N-bit product and returns it with a one-cycle done strobe.
- Also returns the multiplier sequencer to its IDLE state before the next job.

Parameters:
- N, 4, operand width; product is 2N bits.
- NREQ, 2, number of requesters (2..8).
- TIMEOUT, 4*N+8, BUSY-cycle limit; used only with MULT_TIMEOUT_EN.

Ports:
- clock  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  NREQ  per-requester request; held high until own done.
- mcand  input  NREQ x N (packed)  per-requester multiplicand.
- mplier  input  NREQ x N (packed)  per-requester multiplier.
- grant  output  NREQ  one-hot; owner of the current job.
- done  output  NREQ  one-hot, one-cycle pulse; result valid this cycle.
- result  output  2N  product of the last completed job, held until the next capture.
- err  output  1  timeout flag, pulsed with done.
- m_start  output  1  to multiplier sequencer start.
- m_mcand  output  N  registered operand to the datapath.
- m_mplier  output  N  registered operand to the datapath.
- m_ready  input  1  from multiplier sequencer ready.
- m_product  input  2N  from the datapath accumulator/shift register.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; grant, done, result, err, m_start, m_mcand, m_mplier all 0.
  - last_grant=NREQ-1, so requester 0 has first priority.
  - Top level drives the multiplier's active-low reset from ~rst, so both blocks reset together.
- States: IDLE, LAUNCH, BUSY, CAPTURE, RELEASE.
- IDLE:
  - If any req is high, the picker selects the first high req searching from last_grant+1 with wrap-around.
  - On the clock edge, register grant (one-hot), last_grant, and m_mcand/m_mplier from the winner's slice.
  - Next state LAUNCH. With no req, stay in IDLE with all outputs 0.
- LAUNCH: m_start=1 for exactly this cycle; the multiplier leaves its IDLE state. Next state BUSY.
- BUSY:
  - m_start=0; wait for m_ready=1.
  - On the first cycle m_ready is high, register result<=m_product. Next state CAPTURE.
- CAPTURE:
  - done[owner]=1 for this cycle only; result is valid.
  - m_start=1 for this cycle, returning the multiplier from STOPPED to IDLE.
  - Next state RELEASE.
- RELEASE: m_start=0 and grant cleared; the multiplier settles in IDLE. Next state IDLE.
- Latency, grant to done: 2 + (multiplier busy cycles) + 1. For N=4 the multiplier takes 2N+1=9 cycles, giving done 12 cycles after the grant edge.
- Back-to-back throughput: one job per (multiplier cycles + 4).
- Boundary conditions:
  - req dropped mid-job: the job still completes and done is still pulsed.
  - Operand changes after the grant edge: ignored.
  - req still high at done: the requester is eligible again, but rotation favours others.
  - All req high continuously: grants rotate strictly 0,1,..,NREQ-1,0.
  - NREQ=1: degenerates to fixed grant.
  - m_ready high in LAUNCH (protocol violation): ignored; only BUSY samples m_ready.
  - rst asserted in any state: immediate return to reset values; no done is emitted for the aborted job.
- Widths: m_product is captured unmodified; no arithmetic in this block beyond the picker index and the BUSY counter.

Optional Feature:
- Macro: MULT_TIMEOUT_EN.
- Defined:
  - A BUSY cycle counter (clog2(TIMEOUT+1) bits) is cleared on entry to BUSY.
  - If m_ready has not been seen when the count reaches TIMEOUT, go to CAPTURE with result<=0 and err=1 alongside done.
  - The release m_start pulse is still issued.
- Undefined: no counter; err is tied to 0; BUSY waits indefinitely.

Decomposition:
- Package mult_pkg holds:
  - arb_state_t enum (IDLE, LAUNCH, BUSY, CAPTURE, RELEASE);
  - default constants for N and NREQ;
  - the TIMEOUT default expression.
- One sub-module, rr_picker #(NREQ):
  - purely combinational;
  - inputs req and last_grant; outputs one-hot pick and its index plus an any flag.
  - Verified standalone.

Test Plan:
- req=01, mcand0=5, mplier0=3 with behavioural multiplier model → grant=01, one m_start pulse, done=01 exactly once, result=8'd15, then a second m_start pulse in CAPTURE.
- After reset, req=11 simultaneously, op0=5x3, op1=15x15 → first grant=01 with result 15, then grant=10 with result 225; no cycle has two grant bits high.
- req=11 held for 4 jobs → grant sequence 01,10,01,10; each done is 1 cycle wide; the gap between a done and the next grant is 2 cycles.
- Job 0 in progress, req0 dropped in BUSY → done[0] still pulses and result is correct; the arbiter returns to IDLE.
- rst pulsed during BUSY → all outputs 0 in the same cycle, no done; the next req after release is granted to requester 0.
- MULT_TIMEOUT_EN, N=4, m_ready stuck 0 → done=01 and err=1 after 24 BUSY cycles, result=0. Without the macro the arbiter stays in BUSY and err stays 0.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and defaults for the shared-multiplier arbiter.
package mult_pkg;

  // Arbiter job phases, from picking a requester to handing the sequencer back
  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    BUSY,
    CAPTURE,
    RELEASE
  } arb_state_t;

  localparam int N_DEFAULT    = 4;
  localparam int NREQ_DEFAULT = 2;

  // Comfortable margin over the 2N+1 cycles a shift-add multiply needs
  function automatic int timeout_default(input int n);
    return 4 * n + 8;
  endfunction

endpackage

// File: rtl/mult_arbiter_rr_picker.sv
// Combinational round-robin picker: first active request after last_grant.
module rr_picker #(
  parameter int NREQ = 2,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Walk the requesters starting just after the last owner, wrapping around
  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      int j;
      j = (int'(last_grant) + i) % NREQ;
      if (!any && req[j]) begin
        any     = 1'b1;
        pick[j] = 1'b1;
        idx     = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one shift-add multiplier among NREQ requesters.
// Optional BUSY watchdog enabled with macro MULT_TIMEOUT_EN.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int N       = N_DEFAULT,
  parameter int NREQ    = NREQ_DEFAULT,
  parameter int TIMEOUT = timeout_default(N)
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] mcand,
  input  logic [NREQ*N-1:0] mplier,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [2*N-1:0]    result,
  output logic              err,
  output logic              m_start,
  output logic [N-1:0]      m_mcand,
  output logic [N-1:0]      m_mplier,
  input  logic              m_ready,
  input  logic [2*N-1:0]    m_product
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      state, state_next;
  logic [IW-1:0]   last_grant;
  logic [NREQ-1:0] pick;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            timed_out;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req        (req),
    .last_grant (last_grant),
    .pick       (pick),
    .idx        (pick_idx),
    .any        (pick_any)
  );

`ifdef MULT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] busy_cnt;
  logic          err_q;

  // Count BUSY cycles; cleared in LAUNCH so every job starts from zero
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      busy_cnt <= '0;
    end else if (state == LAUNCH) begin
      busy_cnt <= '0;
    end else if (state == BUSY && busy_cnt != CW'(TIMEOUT)) begin
      busy_cnt <= busy_cnt + 1'b1;
    end
  end

  assign timed_out = (state == BUSY) && !m_ready && (busy_cnt == CW'(TIMEOUT - 1));

  // Remember whether BUSY was left by the watchdog rather than by m_ready
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == BUSY) begin
      err_q <= timed_out;
    end
  end

  assign err = err_q && (state == CAPTURE);
`else
  assign timed_out = 1'b0;
  assign err       = 1'b0;
`endif

  // State register plus the job registers loaded at grant and at capture
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      result     <= '0;
      m_mcand    <= '0;
      m_mplier   <= '0;
      last_grant <= IW'(NREQ - 1);
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant      <= pick;
            last_grant <= pick_idx;
            m_mcand    <= mcand[int'(pick_idx) * N +: N];
            m_mplier   <= mplier[int'(pick_idx) * N +: N];
          end
        end
        BUSY: begin
          if (m_ready) begin
            result <= m_product;
          end else if (timed_out) begin
            result <= '0;
          end
        end
        CAPTURE: begin
          grant <= '0;
        end
        default: ;
      endcase
    end
  end

  // Next state and the per-state strobes toward requesters and sequencer
  always_comb begin
    state_next = state;
    m_start    = 1'b0;
    done       = '0;
    case (state)
      IDLE:    if (pick_any) state_next = LAUNCH;
      LAUNCH: begin
        m_start    = 1'b1;
        state_next = BUSY;
      end
      BUSY:    if (m_ready || timed_out) state_next = CAPTURE;
      CAPTURE: begin
        m_start    = 1'b1;
        done       = grant;
        state_next = RELEASE;
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule
